uart_rx_edge_sampler: RTL and testbench
=======================================

Name: uart_rx_edge_sampler

Overview:
Oversampling front end of the UART receiver. It tracks oversampling edges within each bit (edge_count) and bits within a frame (bit_count), and resolves each bit by 3-sample majority vote around mid-bit. It sits directly upstream of the RX control FSM, which consumes edge_count and bit_count and drives enable and sample_en. Resolved bits go to the deserializer and the start, parity and stop checkers.

Parameters:
PRESCALE_W, 6, width of Prescale and edge_count
BIT_CNT_W, 4, width of bit_count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  counter enable from FSM (counter_enable)
sample_en  in  1  sampling enable from FSM (data_sample_en)
RX_IN  in  1  serial line, already synchronised to clk upstream
Prescale  in  PRESCALE_W  oversampling ratio; supported values 8, 16, 32
edge_count  out  PRESCALE_W  edge index within current bit, 0..Prescale-1
bit_count  out  BIT_CNT_W  completed-bit count within current frame
sampled_bit  out  1  majority-voted value of the current bit
sample_valid  out  1  one-cycle pulse: sampled_bit has just updated

Behaviour:
- Reset (async, rst=1): edge_count=0, bit_count=0, sampled_bit=1 (idle line), sample_valid=0, internal samples s0/s1=1. These values apply immediately and hold while rst=1.
- All logic is registered. No combinational path from any input to any output.
- Define half = Prescale>>1 and last = Prescale-1. Both are computed in PRESCALE_W bits; wrap-around is intended.
- Edge counter, enable=0: edge_count <= 0 and bit_count <= 0 on the next edge (synchronous clear).
- Edge counter, enable=1 and edge_count==last: edge_count <= 0 and bit_count <= bit_count+1. bit_count wraps modulo 2^BIT_CNT_W with no saturation; a normal frame is at most 11 bits, so wrap never occurs in legal use.
- Edge counter, enable=1 otherwise: edge_count <= edge_count+1.
- Sampling happens only when enable=1 and sample_en=1:
  - edge_count==half-1: s0 <= RX_IN
  - edge_count==half: s1 <= RX_IN
  - edge_count==half+1: sampled_bit <= majority(s0, s1, RX_IN) and sample_valid <= 1
- As a result, sampled_bit is valid, and sample_valid is high for exactly one cycle, in the cycle where edge_count==half+2. The FSM checks the stop bit from edge_count>=half+2, which matches this timing.
- Example, Prescale=8: samples at edges 3, 4, 5; valid at edge 6.
- sample_valid is 0 in every cycle not covered by the rule above.
- sample_en=0 with enable=1: the counters run, no samples are captured, sample_valid stays 0, and sampled_bit holds its value.
- enable drops mid-bit: the counters clear on the next edge. Partial samples are discarded (s0/s1 keep stale values but are always overwritten before use). No sample_valid is produced for that bit. sampled_bit holds.
- Simultaneous wrap and re-enable: an enable that stays high across the FSM's STOP->START transition continues counting from 0 with no dead cycle.
- Prescale must be changed only while enable=0; a change during enable=1 has undefined effect on the current bit only.
- Prescale values outside {8, 16, 32}: counting still wraps at last, so nothing hangs. For Prescale<4 the sample points alias, and sampled_bit is unspecified.
- Reset asserted mid-frame: all state returns to reset values asynchronously. Operation resumes from edge 0 on the first enabled edge after rst deasserts.

Decomposition:
- Package uart_rx_pkg holds:
  - PRESCALE_W and BIT_CNT_W defaults
  - constants PRESCALE_8/16/32
  - frame-length constant FRAME_BITS_MAX=11
  - a majority3 function
  The RX FSM imports the same package.
- Sub-module uart_rx_edge_bit_counter contains edge_count and bit_count with the enable/clear logic. The sampler and majority registers live in the top module.

Test Plan:
- Prescale=8, enable=sample_en=1, RX_IN=0 for 8 cycles then 1 for 8 cycles -> sampled_bit=0 with sample_valid at edge 6 of bit 0; sampled_bit=1 at edge 6 of bit 1; bit_count=1 after cycle 8 and 2 after cycle 16.
- Prescale=8, RX_IN=1 except 0 at edge 4 only -> sampled_bit=1. RX_IN=0 at edges 3 and 4, 1 at edge 5 -> sampled_bit=0. Exactly one sample_valid per bit in both cases.
- Prescale=16, enable held for 176 cycles -> bit_count=11 and edge_count=0 after the 176th edge. sample_valid at edges 10, 26, 42, ... only when sample_en=1. With sample_en=0 throughout -> no sample_valid and sampled_bit unchanged.
- Prescale=32, enable dropped at edge_count=15 -> edge_count=0 and bit_count=0 next cycle, no sample_valid. Re-enable -> first sample_valid at edge 18.
- rst pulsed at edge_count=5 of bit 3 (Prescale=8) -> edge_count=0, bit_count=0, sampled_bit=1, sample_valid=0 immediately, before the next clk edge. Normal counting after release.
- enable held across a stop-to-start transition (RX_IN low at wrap) -> edge_count goes 7->0 with no idle cycle; bit_count continues incrementing until the FSM deasserts enable.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: default widths, supported prescale ratios and
// the bit-resolution helpers used by the sampler and the RX control FSM.
package uart_rx_pkg;

  localparam int DEFAULT_PRESCALE_W = 6;
  localparam int DEFAULT_BIT_CNT_W  = 4;

  localparam logic [DEFAULT_PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [DEFAULT_PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [DEFAULT_PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  localparam int FRAME_BITS_MAX = 11;

  typedef enum logic [1:0] {
    SMP_NONE,
    SMP_FIRST,
    SMP_SECOND,
    SMP_VOTE
  } sample_point_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter within a bit and completed-bit counter within a
// frame; both clear synchronously whenever the FSM drops enable.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W,
  parameter int BIT_CNT_W  = DEFAULT_BIT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count
);

  logic [PRESCALE_W-1:0] r_edge_count;
  logic [BIT_CNT_W-1:0]  r_bit_count;
  logic [PRESCALE_W-1:0] w_last;

  // Modular subtraction: an out-of-range Prescale still yields a wrap point.
  assign w_last = Prescale - PRESCALE_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_count <= '0;
      r_bit_count  <= '0;
    end else if (!enable) begin
      r_edge_count <= '0;
      r_bit_count  <= '0;
    end else if (r_edge_count == w_last) begin
      r_edge_count <= '0;
      r_bit_count  <= r_bit_count + BIT_CNT_W'(1);
    end else begin
      r_edge_count <= r_edge_count + PRESCALE_W'(1);
    end
  end

  assign edge_count = r_edge_count;
  assign bit_count  = r_bit_count;

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART RX oversampling front end: edge/bit counters plus a 3-sample majority
// vote around mid-bit, producing one sample_valid pulse per resolved bit.
module uart_rx_edge_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W,
  parameter int BIT_CNT_W  = DEFAULT_BIT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sample_en,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  logic [PRESCALE_W-1:0] w_edge_count;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_first;
  logic [PRESCALE_W-1:0] w_vote;
  sample_point_e         w_point;

  logic r_s0;
  logic r_s1;
  logic r_sampled_bit;
  logic r_sample_valid;

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .Prescale   (Prescale),
    .edge_count (w_edge_count),
    .bit_count  (bit_count)
  );

  assign w_half  = Prescale >> 1;
  assign w_first = w_half - PRESCALE_W'(1);
  assign w_vote  = w_half + PRESCALE_W'(1);

  // Earlier sample points win when tiny Prescale values make them alias.
  always_comb begin
    w_point = SMP_NONE;
    if (enable && sample_en) begin
      if (w_edge_count == w_first)
        w_point = SMP_FIRST;
      else if (w_edge_count == w_half)
        w_point = SMP_SECOND;
      else if (w_edge_count == w_vote)
        w_point = SMP_VOTE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0           <= 1'b1;
      r_s1           <= 1'b1;
      r_sampled_bit  <= 1'b1;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      case (w_point)
        SMP_FIRST:  r_s0 <= RX_IN;
        SMP_SECOND: r_s1 <= RX_IN;
        SMP_VOTE: begin
          r_sampled_bit  <= majority3(r_s0, r_s1, RX_IN);
          r_sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign edge_count   = w_edge_count;
  assign sampled_bit  = r_sampled_bit;
  assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Randomized and directed bench for uart_rx_edge_sampler against a
// per-bit reference model built from the sampling-point rules.
module tb_uart_rx_edge_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       sample_en;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       sampled_bit;
  logic       sample_valid;
  logic [11:0] obs;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: integer position in the bit/frame, the line value
  // captured at each oversampling edge, and the last resolved bit.
  int m_e, m_b, P;
  bit m_bit, m_valid;
  bit hist[64];

  uart_rx_edge_sampler #(
    .PRESCALE_W (6),
    .BIT_CNT_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_en    (sample_en),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .edge_count   (edge_count),
    .bit_count    (bit_count),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  assign obs = {edge_count, bit_count, sampled_bit, sample_valid};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] expv();
    return {6'(m_e), 4'(m_b), m_bit, m_valid};
  endfunction

  function automatic void model_reset();
    m_e = 0;
    m_b = 0;
    m_bit = 1'b1;
    m_valid = 1'b0;
    for (int i = 0; i < 64; i++) hist[i] = 1'b1;
  endfunction

  // Bit is resolved from the line values seen at edges half-1, half, half+1.
  function automatic void model_step(input bit en, input bit sen, input bit rx);
    int half;
    int ones;
    half = P / 2;
    m_valid = 1'b0;
    if (en && sen) begin
      if (m_e == half - 1 || m_e == half) begin
        hist[m_e] = rx;
      end else if (m_e == half + 1) begin
        ones = int'(hist[half - 1]) + int'(hist[half]) + int'(rx);
        m_bit = (ones >= 2);
        m_valid = 1'b1;
      end
    end
    if (!en) begin
      m_e = 0;
      m_b = 0;
    end else if (m_e == P - 1) begin
      m_e = 0;
      m_b = (m_b + 1) % 16;
    end else begin
      m_e = m_e + 1;
    end
  endfunction

  task automatic drive(input bit en, input bit sen, input bit rx);
    enable = en;
    sample_en = sen;
    RX_IN = rx;
    @(posedge clk);
    model_step(en, sen, rx);
    #1;
  endtask

  task automatic set_prescale(input int p);
    Prescale = 6'(p);
    P = p;
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    sample_en = 1'b0;
    RX_IN = 1'b1;
    Prescale = 6'd8;
    P = 8;
    model_reset();
    #2;
    vectors++;
    if (obs !== {6'd0, 4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", obs, {6'd0, 4'd0, 1'b1, 1'b0});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (obs !== {6'd0, 4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_held: got %h expected %h", obs, {6'd0, 4'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_basic_p8();
    set_prescale(8);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, (i < 8) ? 1'b0 : 1'b1);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL basic_p8 cyc %0d: got %h expected %h", i, obs, expv());
      end
      if (i == 5 || i == 13) begin
        vectors++;
        if ({edge_count, sampled_bit, sample_valid} !== {6'd6, (i == 13), 1'b1}) begin
          miscompares++;
          $display("FAIL basic_p8_vote cyc %0d: got e=%0d bit=%b v=%b expected e=6 bit=%b v=1",
                   i, edge_count, sampled_bit, sample_valid, (i == 13));
        end
      end
      if (i == 7 || i == 15) begin
        vectors++;
        if (bit_count !== ((i == 7) ? 4'd1 : 4'd2)) begin
          miscompares++;
          $display("FAIL basic_p8_bitcnt cyc %0d: got %0d expected %0d", i, bit_count, (i == 7) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_majority();
    int valids;
    set_prescale(8);
    for (int b = 0; b < 2; b++) begin
      valids = 0;
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 1'b1, (b == 0) ? (m_e != 4) : !(m_e == 3 || m_e == 4));
        if (sample_valid) valids++;
        vectors++;
        if (obs !== expv()) begin
          miscompares++;
          $display("FAIL majority bit %0d cyc %0d: got %h expected %h", b, i, obs, expv());
        end
      end
      vectors++;
      if (valids != 1 || sampled_bit !== (b == 0)) begin
        miscompares++;
        $display("FAIL majority_result bit %0d: got bit=%b valids=%0d expected bit=%b valids=1",
                 b, sampled_bit, valids, (b == 0));
      end
    end
  endtask

  task automatic test_p16_long();
    int valids;
    logic held;
    set_prescale(16);
    valids = 0;
    for (int i = 0; i < 176; i++) begin
      drive(1'b1, 1'b1, 1'($urandom));
      if (sample_valid) valids++;
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL p16_long cyc %0d: got %h expected %h", i, obs, expv());
      end
    end
    vectors++;
    if ({edge_count, bit_count} !== {6'd0, 4'd11} || valids != 11) begin
      miscompares++;
      $display("FAIL p16_frame_end: got e=%0d b=%0d valids=%0d expected e=0 b=11 valids=11",
               edge_count, bit_count, valids);
    end
    drive(1'b0, 1'b0, 1'b1);
    held = sampled_bit;
    valids = 0;
    for (int i = 0; i < 176; i++) begin
      drive(1'b1, 1'b0, 1'($urandom));
      if (sample_valid) valids++;
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL p16_nosample cyc %0d: got %h expected %h", i, obs, expv());
      end
    end
    vectors++;
    if (valids != 0 || sampled_bit !== m_bit) begin
      miscompares++;
      $display("FAIL p16_nosample_hold: got bit=%b valids=%0d expected bit=%b (was %b) valids=0",
               sampled_bit, valids, m_bit, held);
    end
  endtask

  task automatic test_abort_p32();
    int found;
    set_prescale(32);
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'($urandom));
    drive(1'b0, 1'b1, 1'($urandom));
    vectors++;
    if ({edge_count, bit_count, sample_valid} !== {6'd0, 4'd0, 1'b0} || obs !== expv()) begin
      miscompares++;
      $display("FAIL abort_clear: got %h expected %h", obs, expv());
    end
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      drive(1'b1, 1'b1, 1'($urandom));
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL abort_resume cyc %0d: got %h expected %h", i, obs, expv());
      end
      if (sample_valid) found = 1;
    end
    vectors++;
    if (found == 0 || edge_count !== 6'd18) begin
      miscompares++;
      $display("FAIL abort_first_valid: got found=%0d e=%0d expected found=1 e=18", found, edge_count);
    end
  endtask

  task automatic test_async_reset();
    set_prescale(8);
    for (int i = 0; i < 29; i++) drive(1'b1, 1'b1, 1'b0);
    vectors++;
    if ({edge_count, bit_count} !== {6'd5, 4'd3}) begin
      miscompares++;
      $display("FAIL reset_setup: got e=%0d b=%0d expected e=5 b=3", edge_count, bit_count);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (obs !== {6'd0, 4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_midframe: got %h expected %h", obs, {6'd0, 4'd0, 1'b1, 1'b0});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'($urandom));
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL reset_resume cyc %0d: got %h expected %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit rx;
    set_prescale(8);
    for (int b = 0; b < 13; b++) begin
      if (b == 0 || b == 11) rx = 1'b0;
      else if (b == 10 || b == 12) rx = 1'b1;
      else rx = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 1'b1, rx);
        vectors++;
        if (obs !== expv()) begin
          miscompares++;
          $display("FAIL b2b bit %0d cyc %0d: got %h expected %h", b, i, obs, expv());
        end
      end
      if (b == 10) begin
        vectors++;
        if ({edge_count, bit_count} !== {6'd0, 4'd11}) begin
          miscompares++;
          $display("FAIL b2b_wrap: got e=%0d b=%0d expected e=0 b=11", edge_count, bit_count);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int plist[3] = '{8, 16, 32};
    bit sen;
    int len;
    for (int s = 0; s < 30; s++) begin
      set_prescale(plist[$urandom_range(0, 2)]);
      sen = 1'($urandom);
      len = $urandom_range(1, 80);
      for (int i = 0; i < len; i++) begin
        drive(1'b1, sen, 1'($urandom));
        vectors++;
        if (obs !== expv()) begin
          miscompares++;
          $display("FAIL random seg %0d cyc %0d P=%0d: got %h expected %h", s, i, P, obs, expv());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_p8();
    test_majority();
    test_p16_long();
    test_abort_p32();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
